wb_stage: RTL

Writeback stage of the 5-stage pipeline, directly downstream of the memory stage. Holds the MEM/WB pipeline register and captures the memory stage's read data, ALU result and control on each advancing clock edge. It performs load byte/halfword extraction with sign/zero extension, selects memory or ALU data, and drives the register-file write port plus a matching forwarding bus. It also keeps a retired-instruction counter and a sticky misaligned-load error flag.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/load_align.sv | 34 +++
 rtl/wb_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB boundary: load encodings and the pipeline payload.
package wb_pkg;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } load_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_to_reg;
      load_t             load_type;
      logic [XLEN-1:0]   mem_data;
      logic [XLEN-1:0]   alu_result;
   } mem_wb_t;
endpackage

// File: rtl/load_align.sv
// Load byte/halfword extraction with sign/zero extension and misalignment detection.
module load_align
   import wb_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      off_i,
   input  load_t           load_type_i,
   output logic [XLEN-1:0] data_o,
   output logic            misaligned_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel     = word_i[{off_i, 3'b000} +: 8];
      half_sel     = off_i[1] ? word_i[16 +: 16] : word_i[0 +: 16];
      data_o       = word_i;
      misaligned_o = 1'b0;
      case (load_type_i)
         LD_B:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_BU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
         LD_H: begin
            data_o       = {{(XLEN-16){half_sel[15]}}, half_sel};
            misaligned_o = off_i[0];
         end
         LD_HU: begin
            data_o       = {{(XLEN-16){1'b0}}, half_sel};
            misaligned_o = off_i[0];
         end
         // LD_W and any undefined code behave as a full-word load
         default: misaligned_o = (off_i != 2'b00);
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load alignment, RF write/forward port,
// retired counter and sticky misaligned-load flag.
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic [XLEN-1:0]   mem_data_in,
   input  logic [XLEN-1:0]   alu_result_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   input  logic [2:0]        load_type_in,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   output logic [CNT_W-1:0]  retired_count,
   output logic              misalign_err
);
   mem_wb_t          pipe_q, pipe_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [XLEN-1:0]  ld_data;
   logic             ld_mis;
   logic             misaligned;
   logic             advance;

   load_align u_load_align (
      .word_i       (pipe_q.mem_data),
      .off_i        (pipe_q.alu_result[1:0]),
      .load_type_i  (pipe_q.load_type),
      .data_o       (ld_data),
      .misaligned_o (ld_mis)
   );

   assign misaligned = pipe_q.valid & pipe_q.mem_to_reg & ld_mis;
   assign advance    = ~stall | flush;

   // Next state: flush inserts a bubble, stall holds, otherwise capture MEM.
   always_comb begin
      pipe_d = pipe_q;
      cnt_d  = cnt_q;
      err_d  = err_q | misaligned;
      if (flush) begin
         pipe_d = '0;
      end else if (!stall) begin
         pipe_d.valid      = valid_in;
         pipe_d.rd         = rd_in;
         pipe_d.reg_write  = reg_write_in;
         pipe_d.mem_to_reg = mem_to_reg_in;
         pipe_d.load_type  = load_t'(load_type_in);
         pipe_d.mem_data   = mem_data_in;
         pipe_d.alu_result = alu_result_in;
      end
      if (advance && pipe_q.valid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pipe_q <= pipe_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign rf_we         = pipe_q.valid & pipe_q.reg_write & (pipe_q.rd != '0) & ~misaligned;
   assign rf_waddr      = pipe_q.rd;
   assign rf_wdata      = pipe_q.mem_to_reg ? ld_data : pipe_q.alu_result;
   assign fwd_valid     = rf_we;
   assign fwd_rd        = rf_waddr;
   assign fwd_data      = rf_wdata;
   assign retired_count = cnt_q;
   assign misalign_err  = err_q;
endmodule
